// File: rtl/counter_sched_pkg.sv
// Shared state encoding for the interval-timer controller and its bench.
package counter_sched_pkg;

    localparam int unsigned ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/counter_core_en_clr.sv
// Plain WIDTH-bit up-counter; synchronous clear has priority over enable.
module counter_core_en_clr #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sched_ctrl.sv
// Programmable one-shot/periodic interval timer around counter_core_en_clr.
// Define CNT_PRESCALE_EN to build the tick prescaler (divide by ps_div+1).
module counter_sched_ctrl
    import counter_sched_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned PS_WIDTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                pause,
    input  logic                resume,
    input  logic                abort,
    input  logic                periodic,
    input  logic [WIDTH-1:0]    term_val,
    input  logic [PS_WIDTH-1:0] ps_div,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic [ST_W-1:0]     state
);

    state_e           state_q;
    logic [WIDTH-1:0] term_q;
    logic             done_q;
    logic             tick;
    logic             at_term;
    logic             running;
    logic             cnt_clr;
    logic             cnt_en;

    assign at_term = (count == term_q);
    // RUN without a pause request this cycle; pause wins over the tick.
    assign running = (state_q == ST_RUN) && !pause;

`ifdef CNT_PRESCALE_EN
    logic [PS_WIDTH-1:0] ps_q;
    logic [PS_WIDTH-1:0] ps_div_q;

    assign tick = (ps_q == ps_div_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps_q     <= '0;
            ps_div_q <= '0;
        end else if (abort) begin
            ps_q <= '0;
        end else if (start) begin
            ps_q     <= '0;
            ps_div_q <= ps_div;
        end else if (running) begin
            ps_q <= tick ? '0 : ps_q + PS_WIDTH'(1);
        end
    end
`else
    logic unused_ps_div;
    assign unused_ps_div = ^ps_div;
    assign tick          = 1'b1;
`endif

    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (abort || start) begin
            cnt_clr = 1'b1;
        end else if (running && tick) begin
            if (at_term) begin
                cnt_clr = periodic;
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            term_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
            end else if (start) begin
                state_q <= ST_RUN;
                term_q  <= term_val;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSE;
                        end else if (tick && at_term) begin
                            done_q <= 1'b1;
                            if (!periodic) begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (resume) begin
                            state_q <= ST_RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    counter_core_en_clr #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (count)
    );

    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = done_q;
    assign state = state_q;

endmodule
